// File: rtl/dcache_axi_bridge_if.sv
// dcache_axi_bridge_if
// Bundles the D-cache line request/response handshake and the five AXI
// channels (AR, R, AW, W, B) used by dcache_axi_bridge.
//   master : the bridge side (accepts cache requests, drives AXI requests)
//   slave  : the environment side (cache client plus AXI memory slave)
interface dcache_axi_bridge_if;
  // D-cache request / refill response
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_write_en;
  logic [127:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_data;
  // AXI read address
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  ar_address;
  logic [3:0]   ar_id;
  logic [3:0]   ar_length;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic [1:0]   ar_lock;
  logic [3:0]   ar_cache;
  logic [2:0]   ar_protect;
  // AXI read data
  logic         r_valid;
  logic         r_ready;
  logic [3:0]   r_id;
  logic [31:0]  r_data;
  logic [1:0]   r_respond;
  logic         r_last;
  // AXI write address
  logic         aw_valid;
  logic         aw_ready;
  logic [31:0]  aw_address;
  logic [3:0]   aw_id;
  logic [3:0]   aw_length;
  logic [2:0]   aw_size;
  logic [1:0]   aw_burst;
  logic [1:0]   aw_lock;
  logic [3:0]   aw_cache;
  logic [2:0]   aw_protect;
  // AXI write data
  logic         w_valid;
  logic         w_ready;
  logic [3:0]   w_id;
  logic [31:0]  w_data;
  logic [3:0]   w_strobe;
  logic         w_last;
  // AXI write response
  logic         b_valid;
  logic         b_ready;
  logic [3:0]   b_id;
  logic [1:0]   b_respond;

  modport master (
    input  req_valid, req_addr, req_write_en, req_data, resp_ready,
    output req_ready, resp_valid, resp_data,
    output ar_valid, ar_address, ar_id, ar_length, ar_size, ar_burst, ar_lock, ar_cache, ar_protect,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_respond, r_last,
    output r_ready,
    output aw_valid, aw_address, aw_id, aw_length, aw_size, aw_burst, aw_lock, aw_cache, aw_protect,
    input  aw_ready,
    output w_valid, w_id, w_data, w_strobe, w_last,
    input  w_ready,
    input  b_valid, b_id, b_respond,
    output b_ready
  );

  modport slave (
    output req_valid, req_addr, req_write_en, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data,
    input  ar_valid, ar_address, ar_id, ar_length, ar_size, ar_burst, ar_lock, ar_cache, ar_protect,
    output ar_ready,
    output r_valid, r_id, r_data, r_respond, r_last,
    input  r_ready,
    input  aw_valid, aw_address, aw_id, aw_length, aw_size, aw_burst, aw_lock, aw_cache, aw_protect,
    output aw_ready,
    input  w_valid, w_id, w_data, w_strobe, w_last,
    output w_ready,
    output b_valid, b_id, b_respond,
    input  b_ready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
// Converts single 128-bit D-cache line requests into 4-beat, 32-bit AXI INCR
// bursts. A refill (req_write_en=0) issues AR, collects four R beats and
// returns the line on resp_*. A write-back (req_write_en=1) issues AW, sends
// four W beats and waits for B. One transaction is outstanding at a time.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dcache_axi_bridge_if.master (request/response + AXI AR/R/AW/W/B)
// Parameters:
//   AXI_ID     : driven on ar_id/aw_id/w_id
//   CACHE_ATTR : driven on ar_cache/aw_cache
module dcache_axi_bridge #(
  parameter logic [3:0] AXI_ID     = 4'h1,
  parameter logic [3:0] CACHE_ATTR = 4'b0000
) (
  input  logic                       clk,
  input  logic                       rst,
  dcache_axi_bridge_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    RD_RESP = 3'd3,
    WR_ADDR = 3'd4,
    WR_DATA = 3'd5,
    WR_RESP = 3'd6
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [27:0]  addr_q, addr_d;
  logic         wr_q, wr_d;
  logic [127:0] line_q, line_d;

  // Handshake outputs are flops loaded from the next-state decode, so each
  // one equals a decode of the current state with no ready->valid path.
  logic req_ready_q, req_ready_d;
  logic ar_valid_q, ar_valid_d;
  logic r_ready_q, r_ready_d;
  logic resp_valid_q, resp_valid_d;
  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic w_last_q, w_last_d;
  logic b_ready_q, b_ready_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    line_d  = line_q;

    case (state_q)
      IDLE: begin
        // req_ready_q is 0 in the first cycle after reset release
        if (bus.req_valid && req_ready_q) begin
          addr_d  = bus.req_addr[31:4];
          wr_d    = bus.req_write_en;
          line_d  = bus.req_data;
          cnt_d   = 2'd0;
          state_d = bus.req_write_en ? WR_ADDR : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.ar_ready) begin
          cnt_d   = 2'd0;
          state_d = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        // Beat count alone ends the burst; r_last/r_id/r_respond are ignored
        if (bus.r_valid) begin
          line_d[{cnt_q, 5'd0} +: 32] = bus.r_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = RD_RESP;
          end else begin
            state_d = RD_DATA;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      RD_RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RD_RESP;
        end
      end
      WR_ADDR: begin
        if (bus.aw_ready) begin
          cnt_d   = 2'd0;
          state_d = WR_DATA;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (bus.w_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WR_RESP;
          end else begin
            state_d = WR_DATA;
          end
        end else begin
          state_d = WR_DATA;
        end
      end
      WR_RESP: begin
        if (bus.b_valid) begin
          state_d = IDLE;
        end else begin
          state_d = WR_RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    ar_valid_d   = (state_d == RD_ADDR);
    r_ready_d    = (state_d == RD_DATA);
    resp_valid_d = (state_d == RD_RESP);
    aw_valid_d   = (state_d == WR_ADDR);
    w_valid_d    = (state_d == WR_DATA);
    w_last_d     = (state_d == WR_DATA) && (cnt_d == 2'd3);
    b_ready_d    = (state_d == WR_RESP);
  end

  // State, datapath and output registers; reset abandons any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= 28'd0;
      wr_q         <= 1'b0;
      line_q       <= 128'd0;
      req_ready_q  <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      w_last_q     <= 1'b0;
      b_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      line_q       <= line_d;
      req_ready_q  <= req_ready_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      resp_valid_q <= resp_valid_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      w_last_q     <= w_last_d;
      b_ready_q    <= b_ready_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = line_q;

  assign bus.ar_valid   = ar_valid_q;
  assign bus.ar_address = {addr_q, 4'h0};
  assign bus.ar_id      = AXI_ID;
  assign bus.ar_length  = 4'd3;
  assign bus.ar_size    = 3'b010;
  assign bus.ar_burst   = 2'b01;
  assign bus.ar_lock    = 2'b00;
  assign bus.ar_cache   = CACHE_ATTR;
  assign bus.ar_protect = 3'b000;
  assign bus.r_ready    = r_ready_q;

  assign bus.aw_valid   = aw_valid_q;
  assign bus.aw_address = {addr_q, 4'h0};
  assign bus.aw_id      = AXI_ID;
  assign bus.aw_length  = 4'd3;
  assign bus.aw_size    = 3'b010;
  assign bus.aw_burst   = 2'b01;
  assign bus.aw_lock    = 2'b00;
  assign bus.aw_cache   = CACHE_ATTR;
  assign bus.aw_protect = 3'b000;

  assign bus.w_valid    = w_valid_q;
  assign bus.w_id       = AXI_ID;
  assign bus.w_data     = line_q[{cnt_q, 5'd0} +: 32];
  assign bus.w_strobe   = 4'hF;
  assign bus.w_last     = w_last_q;
  assign bus.b_ready    = b_ready_q;

  // Inputs the protocol deliberately ignores
  logic unused_inputs;
  assign unused_inputs = ^{bus.r_last, bus.r_id, bus.r_respond, bus.b_id,
                           bus.b_respond, bus.req_addr[3:0], wr_q};

endmodule

// File: tb/tb_dcache_axi_bridge.sv
module tb_dcache_axi_bridge;

  logic clk;
  logic rst;
  int   cyc;
  int   nvec;
  int   nerr;

  dcache_axi_bridge_if bus();

  dcache_axi_bridge #(.AXI_ID(4'h1), .CACHE_ATTR(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {id, len, size, burst, lock, cache, prot} expected on AR and AW
  localparam logic [21:0] SIDE = {4'h1, 4'd3, 3'b010, 2'b01, 2'b00, 4'b0000, 3'b000};

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;      // read: line the slave returns; write: request line
    int           addr_dly;  // cycles before ar_ready/aw_ready
    int           gap_pct;   // chance of an idle r_valid / w_ready cycle
    int           resp_dly;  // cycles before resp_ready/b_valid
    bit           lat;       // check minimum latency
    bit           pulse;     // pulse req_valid mid-write
    int           abort;     // reset once this many read beats taken (-1 none)
    logic [31:0]  exp_addr;
    logic [127:0] exp_line;  // read: resp_data; write: w beats
  } vec_t;

  logic [127:0] axi_mem [bit [27:0]];
  logic [127:0] ref_mem [bit [27:0]];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.ar_ready   = 1'b0;
    bus.aw_ready   = 1'b0;
    bus.r_valid    = 1'b0;
    bus.w_ready    = 1'b0;
    bus.b_valid    = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
  endtask

  task automatic chk_all_low(input string name);
    chk(name, {bus.req_ready, bus.ar_valid, bus.r_ready, bus.resp_valid,
               bus.aw_valid, bus.w_valid, bus.b_ready}, 7'd0);
    chk({name, "_resp_data"}, bus.resp_data, 128'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int           cyc0;
    int           beat;
    int           wait_n;
    int           guard;
    bit           done;
    bit           first;
    bit           pulsed;
    bit           aborted;
    logic [127:0] cap;
    beat = 0; wait_n = 0; guard = 0; done = 1'b0; first = 1'b1;
    pulsed = 1'b0; aborted = 1'b0; cap = 128'd0;

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_addr     = v.addr;
    bus.req_write_en = v.we;
    bus.req_data     = v.data;
    @(posedge clk);
    #1;
    cyc0 = cyc;
    bus.req_valid = 1'b0;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};

    while (!done && guard < 300) begin
      @(negedge clk);
      guard++;
      idle_inputs();
      chk("req_ready_busy", bus.req_ready, 1'b0);
      if (!v.we) begin
        chk("rd_no_write_valids", {bus.aw_valid, bus.w_valid, bus.b_ready}, 3'd0);
        if (bus.ar_valid) begin
          chk("ar_address", bus.ar_address, v.exp_addr);
          chk("ar_sideband", {bus.ar_id, bus.ar_length, bus.ar_size, bus.ar_burst,
                              bus.ar_lock, bus.ar_cache, bus.ar_protect}, SIDE);
          bus.ar_ready = (wait_n >= v.addr_dly);
          wait_n = bus.ar_ready ? 0 : wait_n + 1;
        end
        bus.r_id      = 4'($urandom);
        bus.r_respond = 2'($urandom);
        bus.r_last    = 1'($urandom);
        if (bus.r_ready && beat < 4) begin
          if (v.abort == beat) begin
            #2 rst = 1'b1;
            #1 chk_all_low("rst_midburst_outputs");
            aborted = 1'b1;
            done = 1'b1;
          end else if ($urandom_range(0, 99) >= v.gap_pct) begin
            bus.r_valid = 1'b1;
            bus.r_data  = v.data[beat*32 +: 32];
            beat++;
          end
        end
        if (bus.resp_valid) begin
          if (first && v.lat) chk("rd_latency", cyc - cyc0, 5);
          first = 1'b0;
          chk("resp_data", bus.resp_data, v.exp_line);
          chk("rd_beat_count", beat, 4);
          bus.resp_ready = (wait_n >= v.resp_dly);
          wait_n++;
          if (bus.resp_ready) done = 1'b1;
        end
      end else begin
        chk("wr_no_read_valids", {bus.ar_valid, bus.r_ready, bus.resp_valid}, 3'd0);
        if (bus.aw_valid) begin
          chk("aw_address", bus.aw_address, v.exp_addr);
          chk("aw_sideband", {bus.aw_id, bus.aw_length, bus.aw_size, bus.aw_burst,
                              bus.aw_lock, bus.aw_cache, bus.aw_protect}, SIDE);
          bus.aw_ready = (wait_n >= v.addr_dly);
          wait_n = bus.aw_ready ? 0 : wait_n + 1;
        end
        if (bus.w_valid) begin
          if (v.pulse && beat == 1 && !pulsed) begin
            bus.req_valid    = 1'b1;
            bus.req_write_en = 1'b0;
            bus.req_addr     = ~v.addr;
            bus.req_data     = ~v.data;
            pulsed = 1'b1;
          end
          chk("w_data", bus.w_data, v.exp_line[beat*32 +: 32]);
          chk("w_strobe_id", {bus.w_strobe, bus.w_id}, 8'hF1);
          chk("w_last", bus.w_last, (beat == 3));
          bus.w_ready = ($urandom_range(0, 99) >= v.gap_pct);
          if (bus.w_ready) begin
            cap[beat*32 +: 32] = bus.w_data;
            beat++;
          end
        end
        if (bus.b_ready) begin
          if (first && v.lat) chk("b_ready_latency", cyc - cyc0, 5);
          first = 1'b0;
          chk("wr_beat_count", beat, 4);
          bus.b_id      = 4'($urandom);
          bus.b_respond = 2'($urandom);
          bus.b_valid   = (wait_n >= v.resp_dly);
          wait_n++;
          if (bus.b_valid) done = 1'b1;
        end
      end
    end

    if (!done) begin
      nerr++;
      $display("FAIL timeout: transaction at %h did not complete in 300 cycles", v.addr);
    end
    if (aborted) begin
      repeat (2) @(negedge clk);
      chk_all_low("rst_held_outputs");
      rst = 1'b0;
      @(posedge clk);
      #1 chk("req_ready_after_release", bus.req_ready, 1'b1);
    end else begin
      @(negedge clk);
      idle_inputs();
      chk("single_resp_handshake", {bus.resp_valid, bus.b_ready}, 2'd0);
      chk("req_ready_return", bus.req_ready, 1'b1);
      if (v.lat && v.we) chk("wr_req_ready_latency", cyc - cyc0, 6);
      if (v.we) axi_mem[v.addr[31:4]] = cap;
    end
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    rst = 1'b1;
    idle_inputs();
    bus.req_addr = 32'd0; bus.req_write_en = 1'b0; bus.req_data = 128'd0;
    bus.r_data = 32'd0; bus.r_id = 4'd0; bus.r_respond = 2'd0; bus.r_last = 1'b0;
    bus.b_id = 4'd0; bus.b_respond = 2'd0;

    repeat (3) @(negedge clk);
    chk_all_low("reset_outputs");
    rst = 1'b0;
    @(posedge clk);
    #1 chk("req_ready_first_cycle", bus.req_ready, 1'b1);

    // Directed vectors
    tbl[0] = '{1'b0, 32'h1FC0_0014, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 0, 1'b1, 1'b0, -1,
               32'h1FC0_0010, 128'h00000044_00000033_00000022_00000011};
    tbl[1] = '{1'b1, 32'h0000_1238, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 0, 0, 1'b1, 1'b0, -1,
               32'h0000_1230, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
    tbl[2] = '{1'b0, 32'h8000_00FF, {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001},
               3, 50, 5, 1'b0, 1'b0, -1,
               32'h8000_00F0, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001};
    tbl[3] = '{1'b1, 32'h4000_0A0C, 128'h76543210_FEDCBA98_01234567_89ABCDEF, 2, 40, 3, 1'b0, 1'b1, -1,
               32'h4000_0A00, 128'h76543210_FEDCBA98_01234567_89ABCDEF};
    tbl[4] = '{1'b0, 32'h2000_0040, {32'h5, 32'h6, 32'h7, 32'h8}, 0, 0, 0, 1'b0, 1'b0, 2,
               32'h2000_0040, 128'd0};
    tbl[5] = '{1'b0, 32'h2000_0048, {32'hA1, 32'hB2, 32'hC3, 32'hD4}, 0, 0, 0, 1'b1, 1'b0, -1,
               32'h2000_0040, 128'h000000A1_000000B2_000000C3_000000D4};
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Randomized traffic over a few lines; reads return what earlier writes stored
    for (int n = 0; n < 30; n++) begin
      bit [27:0] ln;
      ln = 28'h0000100 + 28'($urandom_range(0, 3));
      if (!ref_mem.exists(ln)) begin
        ref_mem[ln] = {$urandom, $urandom, $urandom, $urandom};
        axi_mem[ln] = ref_mem[ln];
      end
      rv.we       = 1'($urandom);
      rv.addr     = {ln, 4'($urandom)};
      rv.addr_dly = $urandom_range(0, 3);
      rv.gap_pct  = $urandom_range(0, 50);
      rv.resp_dly = $urandom_range(0, 3);
      rv.lat      = 1'b0;
      rv.pulse    = rv.we ? 1'($urandom) : 1'b0;
      rv.abort    = -1;
      rv.exp_addr = {ln, 4'h0};
      if (rv.we) begin
        rv.data     = {$urandom, $urandom, $urandom, $urandom};
        rv.exp_line = rv.data;
        ref_mem[ln] = rv.data;
      end else begin
        rv.data     = axi_mem[ln];
        rv.exp_line = ref_mem[ln];
      end
      run_vec(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
